// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared constants for the APB master bridge.
// State encoding, default bus widths and the timeout counter width.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 8;

endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: command/response stream plus APB bus signals.
// master modport is the bridge's view; slave modport is the host/responder view.
interface apb_master_bridge_if
  import apb_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              pSel;
  logic              pEnable;
  logic              pWrite;
  logic [ADDR_W-1:0] pAddr;
  logic [DATA_W-1:0] pWdata;
  logic [DATA_W-1:0] pReadData;
  logic              pReady;
  logic              pSlvErr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
           pReadData, pReady, pSlvErr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           pSel, pEnable, pWrite, pAddr, pWdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
           pReadData, pReady, pSlvErr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           pSel, pEnable, pWrite, pAddr, pWdata
  );
endinterface

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: counts ACCESS wait cycles; term_o flags the cycle whose
// increment would reach LIMIT. Only built when APB_MASTER_TIMEOUT_EN is defined.
module apb_timeout_cnt
  import apb_master_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic pClk,
  input  logic pReset,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next count: clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign term_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command stream to APB transfers, one
// outstanding transfer, one response per command.
// Optional access timeout: define APB_MASTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a command (req_ready high once out of reset)
// SETUP  | APB setup phase, pSel=1 pEnable=0
// ACCESS | APB access phase, waits for pReady (or timeout)
// RESP   | response held on rsp_* until rsp_ready
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                pClk,
  input  logic                pReset,
  apb_master_bridge_if.master bus
);
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be 1..255");
  end

  apb_state_t        state_q, state_d;
  logic              init_q;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              timeout;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .pClk   (pClk),
    .pReset (pReset),
    .clr_i  (state_q == SETUP),
    .en_i   ((state_q == ACCESS) && !bus.pReady),
    .term_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // next-state and captured-data logic; pReady beats a same-cycle timeout
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (init_q && bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.pReady) begin
          rdata_d = (!write_q && !bus.pSlvErr) ? bus.pReadData : '0;
          err_d   = bus.pSlvErr;
          state_d = RESP;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and data registers; init_q keeps req_ready low during reset
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = init_q && (state_q == IDLE);
  assign bus.pSel      = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.pEnable   = (state_q == ACCESS);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.pWrite    = write_q;
  assign bus.pAddr     = addr_q;
  assign bus.pWdata    = wdata_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule
